// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: operand forwarding, load-use / memory / multi-cycle-EX stalls, branch flush.
// Optional perf counters (stall_cycles, flush_events) enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_mc #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              dmem_write_d,
    input  logic [REG_AW-1:0] rs1_x,
    input  logic [REG_AW-1:0] rs2_x,
    input  logic [REG_AW-1:0] rd_x,
    input  logic              is_load_x,
    input  logic              pc_src_x,
    input  logic              ex_busy_x,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rs2_m,
    input  logic              reg_write_m,
    input  logic              dmem_write_m,
    input  logic              dmem_req_m,
    input  logic              dmem_ready_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_x,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_x,
    output logic              flush_w,
    output logic [1:0]        forward_a_x,
    output logic [1:0]        forward_b_x,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events,
`endif
    output logic              forward_m
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, EX_WAIT} state_t;

    localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       lu_pend_q, lu_pend_d;

    logic mem_wait, lu_hit, lu_active;
    logic st_f, st_d, st_x, st_m, fl_d, fl_x, fl_w;

    always_comb begin
        forward_a_x = 2'b00;
        if (rs1_x != '0 && reg_write_m && rs1_x == rd_m)      forward_a_x = 2'b10;
        else if (rs1_x != '0 && reg_write_w && rs1_x == rd_w) forward_a_x = 2'b01;
        forward_b_x = 2'b00;
        if (rs2_x != '0 && reg_write_m && rs2_x == rd_m)      forward_b_x = 2'b10;
        else if (rs2_x != '0 && reg_write_w && rs2_x == rd_w) forward_b_x = 2'b01;
    end

    assign forward_m = (rs2_m != '0) & reg_write_w & dmem_write_m & (rs2_m == rd_w);

    assign mem_wait = dmem_req_m & ~dmem_ready_m;
    assign lu_hit   = is_load_x & (rd_x != '0) &
                      ((rs1_d == rd_x) | ((rs2_d == rd_x) & ~dmem_write_d));
    // A wait that pre-empted LU_STALL leaves lu_pend_q set; the first cycle after
    // the wait drops is treated as an LU_STALL cycle so the total stall stays exact.
    assign lu_active = (state_q == LU_STALL) ||
                       (((state_q == MEM_WAIT) || (state_q == EX_WAIT)) && lu_pend_q);

    always_comb begin
        state_d   = RUN;
        cnt_d     = cnt_q;
        lu_pend_d = lu_pend_q;
        st_f = 1'b0; st_d = 1'b0; st_x = 1'b0; st_m = 1'b0;
        fl_d = 1'b0; fl_x = 1'b0; fl_w = 1'b0;
        if (mem_wait) begin
            st_f = 1'b1; st_d = 1'b1; st_x = 1'b1; st_m = 1'b1; fl_w = 1'b1;
            state_d = MEM_WAIT;
            if (state_q == LU_STALL) lu_pend_d = 1'b1;
        end else if (ex_busy_x) begin
            st_f = 1'b1; st_d = 1'b1; st_x = 1'b1;
            state_d = EX_WAIT;
            if (state_q == LU_STALL) lu_pend_d = 1'b1;
        end else if (lu_active) begin
            st_f = 1'b1; st_d = 1'b1; fl_x = 1'b1;
            lu_pend_d = 1'b0;
            if (cnt_q != 2'd0) begin
                state_d = LU_STALL;
                cnt_d   = cnt_q - 2'd1;
            end
        end else if (lu_hit) begin
            st_f = 1'b1; st_d = 1'b1; fl_x = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = LU_STALL;
                cnt_d   = CNT_INIT;
            end
        end else if (pc_src_x) begin
            fl_d = 1'b1; fl_x = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= 2'd0;
            lu_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lu_pend_q <= lu_pend_d;
        end
    end

    assign stall_f = ~rst & st_f;
    assign stall_d = ~rst & st_d;
    assign stall_x = ~rst & st_x;
    assign stall_m = ~rst & st_m;
    assign flush_d = ~rst & fl_d;
    assign flush_x = ~rst & fl_x;
    assign flush_w = ~rst & fl_w;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_d && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: two instances (LOAD_LAT=1 and LOAD_LAT=3) share all inputs.
module tb_hazard_ctrl_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rs2_m, rd_w;
    logic       dmem_write_d, is_load_x, pc_src_x, ex_busy_x;
    logic       reg_write_m, dmem_write_m, dmem_req_m, dmem_ready_m, reg_write_w;

    logic       sf1, sd1, sx1, sm1, fd1, fx1, fw1, fm1;
    logic       sf3, sd3, sx3, sm3, fd3, fx3, fw3, fm3;
    logic [1:0] fa1, fb1, fa3, fb3;
    logic [6:0] ctrl1, ctrl3;
    assign ctrl1 = {sf1, sd1, sx1, sm1, fd1, fx1, fw1};
    assign ctrl3 = {sf3, sd3, sx3, sm3, fd3, fx3, fw3};

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .dmem_write_d(dmem_write_d),
        .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .is_load_x(is_load_x), .pc_src_x(pc_src_x),
        .ex_busy_x(ex_busy_x), .rd_m(rd_m), .rs2_m(rs2_m), .reg_write_m(reg_write_m),
        .dmem_write_m(dmem_write_m), .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
        .rd_w(rd_w), .reg_write_w(reg_write_w), .stall_f(sf1), .stall_d(sd1), .stall_x(sx1),
        .stall_m(sm1), .flush_d(fd1), .flush_x(fx1), .flush_w(fw1), .forward_a_x(fa1),
        .forward_b_x(fb1), .forward_m(fm1));

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .dmem_write_d(dmem_write_d),
        .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .is_load_x(is_load_x), .pc_src_x(pc_src_x),
        .ex_busy_x(ex_busy_x), .rd_m(rd_m), .rs2_m(rs2_m), .reg_write_m(reg_write_m),
        .dmem_write_m(dmem_write_m), .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
        .rd_w(rd_w), .reg_write_w(reg_write_w), .stall_f(sf3), .stall_d(sd3), .stall_x(sx3),
        .stall_m(sm3), .flush_d(fd3), .flush_x(fx3), .flush_w(fw3), .forward_a_x(fa3),
        .forward_b_x(fb3), .forward_m(fm3));

    int errors = 0;
    int checks = 0;

    // ctrl bit order: {stall_f, stall_d, stall_x, stall_m, flush_d, flush_x, flush_w}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_EX   = 7'b1110000;
    localparam logic [6:0] C_BR   = 7'b0000110;

    typedef struct {
        logic [4:0] rs1x, rs2x, rdm, rdw, rs2m, rs1d, rs2d, rdx;
        logic [8:0] flags;  // {rw_m, rw_w, dmw_m, dmw_d, ld_x, req, rdy, busy, pc}
        logic [1:0] fa, fb;
        logic       fm;
        logic [6:0] ctrl;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [4:0] rs1x, rs2x, rdm, rdw, rs2m, rs1d, rs2d, rdx,
                                input logic [8:0] flags, input logic [1:0] fa, fb,
                                input logic fm, input logic [6:0] ctrl);
        vec_t v;
        v.rs1x = rs1x; v.rs2x = rs2x; v.rdm = rdm; v.rdw = rdw; v.rs2m = rs2m;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rdx = rdx; v.flags = flags;
        v.fa = fa; v.fb = fb; v.fm = fm; v.ctrl = ctrl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic clr();
        rs1_d = '0; rs2_d = '0; rs1_x = '0; rs2_x = '0; rd_x = '0; rd_m = '0; rs2_m = '0; rd_w = '0;
        dmem_write_d = 0; is_load_x = 0; pc_src_x = 0; ex_busy_x = 0; reg_write_m = 0;
        dmem_write_m = 0; dmem_req_m = 0; dmem_ready_m = 0; reg_write_w = 0;
    endtask

    task automatic apply(input vec_t v);
        rs1_x = v.rs1x; rs2_x = v.rs2x; rd_m = v.rdm; rd_w = v.rdw; rs2_m = v.rs2m;
        rs1_d = v.rs1d; rs2_d = v.rs2d; rd_x = v.rdx;
        {reg_write_m, reg_write_w, dmem_write_m, dmem_write_d, is_load_x,
         dmem_req_m, dmem_ready_m, ex_busy_x, pc_src_x} = v.flags;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000000000, 2'b00, 2'b00, 0, C_NONE);
        vecs[1]  = mk(3, 0, 3, 0, 0, 0, 0, 0, 9'b100000000, 2'b10, 2'b00, 0, C_NONE);
        vecs[2]  = mk(3, 3, 3, 3, 0, 0, 0, 0, 9'b110000000, 2'b10, 2'b10, 0, C_NONE);
        vecs[3]  = mk(4, 0, 0, 4, 0, 0, 0, 0, 9'b010000000, 2'b01, 2'b00, 0, C_NONE);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b110000000, 2'b00, 2'b00, 0, C_NONE);
        vecs[5]  = mk(0, 6, 6, 6, 0, 0, 0, 0, 9'b010000000, 2'b00, 2'b01, 0, C_NONE);
        vecs[6]  = mk(0, 0, 0, 9, 9, 0, 0, 0, 9'b011000000, 2'b00, 2'b00, 1, C_NONE);
        vecs[7]  = mk(0, 0, 0, 9, 9, 0, 0, 0, 9'b010000000, 2'b00, 2'b00, 0, C_NONE);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b011000000, 2'b00, 2'b00, 0, C_NONE);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000001000, 2'b00, 2'b00, 0, C_MEM);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000001100, 2'b00, 2'b00, 0, C_NONE);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000000010, 2'b00, 2'b00, 0, C_EX);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000000001, 2'b00, 2'b00, 0, C_BR);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000000011, 2'b00, 2'b00, 0, C_EX);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000001010, 2'b00, 2'b00, 0, C_MEM);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9'b000010000, 2'b00, 2'b00, 0, C_NONE);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 5, 5, 9'b000110000, 2'b00, 2'b00, 0, C_NONE);
        vecs[17] = mk(0, 0, 0, 0, 0, 2, 4, 5, 9'b000010000, 2'b00, 2'b00, 0, C_NONE);

        // Reset with every stall source active: controls must still read 0.
        clr();
        rst = 1'b1;
        dmem_req_m = 1; ex_busy_x = 1; pc_src_x = 1;
        rs1_x = 7; rd_m = 7; reg_write_m = 1;
        @(negedge clk);
        chk("reset_ctrl_l1", {1'b0, ctrl1}, {1'b0, C_NONE});
        chk("reset_ctrl_l3", {1'b0, ctrl3}, {1'b0, C_NONE});
        chk("reset_fwd_a", {6'b0, fa3}, 8'b10);
        tick();
        rst = 1'b0;
        clr();

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_ctrl_l1", i), {1'b0, ctrl1}, {1'b0, vecs[i].ctrl});
            chk($sformatf("vec%0d_ctrl_l3", i), {1'b0, ctrl3}, {1'b0, vecs[i].ctrl});
            chk($sformatf("vec%0d_fwd_a", i), {6'b0, fa3}, {6'b0, vecs[i].fa});
            chk($sformatf("vec%0d_fwd_b", i), {6'b0, fb3}, {6'b0, vecs[i].fb});
            chk($sformatf("vec%0d_fwd_m", i), {7'b0, fm3}, {7'b0, vecs[i].fm});
            chk($sformatf("vec%0d_fwd_l1", i), {3'b0, fa1, fb1, fm1}, {3'b0, vecs[i].fa, vecs[i].fb, vecs[i].fm});
            tick();
        end
        clr();

        // Load-use on rs1: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 stalls three.
        is_load_x = 1; rd_x = 5; rs1_d = 5;
        @(negedge clk);
        chk("lu_c0_l1", {1'b0, ctrl1}, {1'b0, C_LU});
        chk("lu_c0_l3", {1'b0, ctrl3}, {1'b0, C_LU});
        tick();
        clr();
        @(negedge clk);
        chk("lu_c1_l1", {1'b0, ctrl1}, {1'b0, C_NONE});
        chk("lu_c1_l3", {1'b0, ctrl3}, {1'b0, C_LU});
        tick();
        @(negedge clk);
        chk("lu_c2_l1", {1'b0, ctrl1}, {1'b0, C_NONE});
        chk("lu_c2_l3", {1'b0, ctrl3}, {1'b0, C_LU});
        tick();
        @(negedge clk);
        chk("lu_c3_l3", {1'b0, ctrl3}, {1'b0, C_NONE});
        tick();

        // Load-use on rs2 (non-store), then mem_wait for 4 cycles while LU_STALL has cnt=1.
        is_load_x = 1; rd_x = 5; rs2_d = 5;
        @(negedge clk);
        chk("lumw_c0_l3", {1'b0, ctrl3}, {1'b0, C_LU});
        tick();
        clr();
        dmem_req_m = 1; dmem_ready_m = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("lumw_wait%0d_l3", k), {1'b0, ctrl3}, {1'b0, C_MEM});
            tick();
        end
        clr();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("lumw_resume%0d_l3", k), {1'b0, ctrl3}, {1'b0, C_LU});
            chk($sformatf("lumw_resume%0d_l1", k), {1'b0, ctrl1}, {1'b0, C_NONE});
            tick();
        end
        @(negedge clk);
        chk("lumw_done_l3", {1'b0, ctrl3}, {1'b0, C_NONE});
        tick();

        // Taken branch held behind a busy X op: flush only once busy drops.
        pc_src_x = 1; ex_busy_x = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("brbusy%0d_l3", k), {1'b0, ctrl3}, {1'b0, C_EX});
            tick();
        end
        ex_busy_x = 0;
        @(negedge clk);
        chk("brbusy_release_l3", {1'b0, ctrl3}, {1'b0, C_BR});
        chk("brbusy_release_l1", {1'b0, ctrl1}, {1'b0, C_BR});
        tick();
        clr();
        @(negedge clk);
        chk("brbusy_after_l3", {1'b0, ctrl3}, {1'b0, C_NONE});
        tick();

        // Reset pulsed mid-LU_STALL.
        is_load_x = 1; rd_x = 5; rs1_d = 5;
        @(negedge clk);
        chk("rstlu_c0_l3", {1'b0, ctrl3}, {1'b0, C_LU});
        tick();
        clr();
        @(negedge clk);
        chk("rstlu_c1_l3", {1'b0, ctrl3}, {1'b0, C_LU});
        #1;
        rst = 1'b1;
        rs1_x = 7; rd_m = 7; reg_write_m = 1;
        #1;
        chk("rstlu_async_ctrl", {1'b0, ctrl3}, {1'b0, C_NONE});
        chk("rstlu_async_fwd_a", {6'b0, fa3}, 8'b10);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstlu_post0_l3", {1'b0, ctrl3}, {1'b0, C_NONE});
        chk("rstlu_post_fwd_a", {6'b0, fa3}, 8'b10);
        tick();
        @(negedge clk);
        chk("rstlu_post1_l3", {1'b0, ctrl3}, {1'b0, C_NONE});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
